// File: rtl/usb_tx_pkg.sv
// Shared types and line-state constants for the USB transmit bit-stuffer / NRZI encoder.
// Optional build macro: USB_TX_LOW_SPEED_EN selects low-speed J/K polarity.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DATA     = 3'd1,
        ST_EOP_SE0A = 3'd2,
        ST_EOP_SE0B = 3'd3,
        ST_EOP_J    = 3'd4
    } state_t;

    localparam int unsigned CNT_W       = 3;
    localparam int unsigned STUFF_LIMIT = 6;

    // Line states packed as {dp, dm}
`ifdef USB_TX_LOW_SPEED_EN
    localparam logic [1:0] LINE_J = 2'b01;
    localparam logic [1:0] LINE_K = 2'b10;
`else
    localparam logic [1:0] LINE_J = 2'b10;
    localparam logic [1:0] LINE_K = 2'b01;
`endif
    localparam logic [1:0] LINE_SE0 = 2'b00;

    // NRZI toggle between the two differential data states
    function automatic logic [1:0] line_toggle(input logic [1:0] line);
        return (line == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/usb_tx_bitstuff_nrzi.sv
// USB transmit back end: bit stuffing, NRZI line coding and EOP generation.
// Optional build macro: USB_TX_LOW_SPEED_EN (low-speed J/K polarity, via usb_tx_pkg).
module usb_tx_bitstuff_nrzi
    import usb_tx_pkg::*;
(
    input  logic clk,
    input  logic nRST,
    input  logic bit_tick,
    input  logic tx_start,
    input  logic bit_in,
    input  logic bit_avail,
    input  logic pkt_end,
    output logic bit_req,
    output logic dp,
    output logic dm,
    output logic oe,
    output logic busy,
    output logic done,
    output logic tx_err
);

    state_t             state_q;
    logic [CNT_W-1:0]   ones_q;
    logic [1:0]         line_q;
    logic               oe_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic               stuff_due;

    assign stuff_due = (ones_q == CNT_W'(STUFF_LIMIT));

    // Consume strobe: upstream shifts on the same edge that samples bit_in
    assign bit_req = bit_tick & (state_q == ST_DATA) & bit_avail & ~stuff_due;

    assign dp     = line_q[1];
    assign dm     = line_q[0];
    assign oe     = oe_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign tx_err = err_q;

    // Packet FSM with registered line drive; stuffing outranks end/underrun detection
    always_ff @(posedge clk) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            ones_q  <= '0;
            line_q  <= LINE_J;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tx_start) begin
                        state_q <= ST_DATA;
                        line_q  <= LINE_J;
                        oe_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        ones_q  <= '0;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        if (stuff_due) begin
                            line_q <= line_toggle(line_q);
                            ones_q <= '0;
                        end else if (bit_avail) begin
                            if (bit_in) begin
                                ones_q <= ones_q + CNT_W'(1);
                            end else begin
                                line_q <= line_toggle(line_q);
                                ones_q <= '0;
                            end
                        end else begin
                            state_q <= ST_EOP_SE0A;
                            line_q  <= LINE_SE0;
                            ones_q  <= '0;
                            err_q   <= ~pkt_end;
                        end
                    end
                end
                ST_EOP_SE0A: begin
                    if (bit_tick) begin
                        state_q <= ST_EOP_SE0B;
                        line_q  <= LINE_SE0;
                    end
                end
                ST_EOP_SE0B: begin
                    if (bit_tick) begin
                        state_q <= ST_EOP_J;
                        line_q  <= LINE_J;
                    end
                end
                ST_EOP_J: begin
                    if (bit_tick) begin
                        state_q <= ST_IDLE;
                        line_q  <= LINE_J;
                        oe_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    line_q  <= LINE_J;
                    oe_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    ones_q  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_bitstuff_nrzi.sv
// Self-checking bench for usb_tx_bitstuff_nrzi: directed packets plus random packets
// compared against a per-bit-time expected line stream built from the packet contents.
module tb_usb_tx_bitstuff_nrzi;

`ifdef USB_TX_LOW_SPEED_EN
    localparam logic [1:0] J_L = 2'b01;
    localparam logic [1:0] K_L = 2'b10;
`else
    localparam logic [1:0] J_L = 2'b10;
    localparam logic [1:0] K_L = 2'b01;
`endif
    localparam logic [1:0] SE0_L = 2'b00;

    typedef struct packed {
        logic [1:0] ln;
        logic       req;
        logic       oe;
        logic       busy;
        logic       done;
        logic       err;
    } slot_t;

    logic clk = 1'b0;
    logic nRST, bit_tick, tx_start, bit_in, bit_avail, pkt_end;
    logic bit_req, dp, dm, oe, busy, done, tx_err;

    int   checks = 0;
    int   errors = 0;

    bit    pkt_q[$];
    bit    up_q[$];
    slot_t exp_q[$];

    always #5 clk = ~clk;

    usb_tx_bitstuff_nrzi dut (
        .clk      (clk),
        .nRST     (nRST),
        .bit_tick (bit_tick),
        .tx_start (tx_start),
        .bit_in   (bit_in),
        .bit_avail(bit_avail),
        .pkt_end  (pkt_end),
        .bit_req  (bit_req),
        .dp       (dp),
        .dm       (dm),
        .oe       (oe),
        .busy     (busy),
        .done     (done),
        .tx_err   (tx_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] tog(input logic [1:0] l);
        return (l == J_L) ? K_L : J_L;
    endfunction

    function automatic slot_t mk(input logic [1:0] l, input logic r, input logic o,
                                 input logic b, input logic d, input logic e);
        slot_t s;
        s.ln = l; s.req = r; s.oe = o; s.busy = b; s.done = d; s.err = e;
        return s;
    endfunction

    // Expected bit-time stream: stuffed, NRZI-coded data, then SE0, SE0, J, back to idle
    task automatic build_model(input bit underrun);
        int         run;
        logic [1:0] l;
        run = 0;
        l   = J_L;
        exp_q.delete();
        foreach (pkt_q[i]) begin
            if (run == 6) begin
                l = tog(l); run = 0;
                exp_q.push_back(mk(l, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
            end
            if (pkt_q[i]) run++;
            else begin l = tog(l); run = 0; end
            exp_q.push_back(mk(l, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        end
        if (run == 6) begin
            l = tog(l);
            exp_q.push_back(mk(l, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        end
        exp_q.push_back(mk(SE0_L, 1'b0, 1'b1, 1'b1, 1'b0, underrun));
        exp_q.push_back(mk(SE0_L, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(J_L,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(J_L,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) pkt_q.push_back(b[i]);
    endtask

    // Send pkt_q; abort_ticks>0 stops driving after that many bit times (for reset tests)
    task automatic run_packet(input bit underrun, input int unsigned gap_max,
                              input int unsigned abort_ticks, input bit poke_start);
        slot_t       s;
        slot_t       cur;
        int unsigned gap_cnt;
        int unsigned ticks;
        int unsigned guard;
        logic        took;
        build_model(underrun);
        up_q = pkt_q;
        // start request (inputs driven 1 time unit after the edge)
        bit_tick = 1'b0; tx_start = 1'b1; bit_avail = 1'b0; pkt_end = 1'b0; bit_in = 1'b0;
        @(posedge clk); #1;
        tx_start = 1'b0;
        check("start_line", 32'({dp, dm}), 32'(J_L));
        check("start_oe",   32'(oe),   32'd1);
        check("start_busy", 32'(busy), 32'd1);
        cur     = mk(J_L, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        gap_cnt = $urandom_range(0, gap_max - 1);
        ticks   = 0;
        guard   = 0;
        while (exp_q.size() > 0) begin
            if (abort_ticks != 0 && ticks == abort_ticks) return;
            bit_tick  = (gap_cnt == 0);
            tx_start  = poke_start ? ($urandom_range(0, 3) == 0) : 1'b0;
            bit_avail = (up_q.size() > 0);
            bit_in    = bit_avail ? up_q[0] : 1'($urandom_range(0, 1));
            pkt_end   = (up_q.size() == 0) && !underrun;
            #1;
            if (bit_tick) begin
                s = exp_q.pop_front();
                check("bit_req", 32'(bit_req), 32'(s.req));
            end else begin
                check("bit_req_notick", 32'(bit_req), 32'd0);
            end
            took = bit_req;
            @(posedge clk); #1;
            if (took && up_q.size() > 0) void'(up_q.pop_front());
            if (bit_tick) begin
                ticks++;
                check("line",   32'({dp, dm}), 32'(s.ln));
                check("oe",     32'(oe),     32'(s.oe));
                check("busy",   32'(busy),   32'(s.busy));
                check("done",   32'(done),   32'(s.done));
                check("tx_err", 32'(tx_err), 32'(s.err));
                cur = s;
                gap_cnt = $urandom_range(0, gap_max - 1);
            end else begin
                check("hold_line", 32'({dp, dm}), 32'(cur.ln));
                check("hold_oe",   32'(oe),       32'(cur.oe));
                check("hold_done", 32'(done),     32'd0);
                check("hold_err",  32'(tx_err),   32'd0);
                gap_cnt--;
            end
            guard++;
            if (guard > 5000) begin
                check("packet_timeout", 32'd1, 32'd0);
                exp_q.delete();
            end
        end
        tx_start = 1'b0;
        bit_tick = 1'b0;
    endtask

    // Idle with ticks and data offered: nothing may be consumed or driven
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bit_tick = 1'($urandom_range(0, 1)); bit_avail = 1'b1; bit_in = 1'b0;
            pkt_end = 1'b0; tx_start = 1'b0;
            #1;
            check("idle_bit_req", 32'(bit_req), 32'd0);
            @(posedge clk); #1;
            check("idle_line", 32'({dp, dm}), 32'(J_L));
            check("idle_oe",   32'(oe),   32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
            check("idle_err",  32'(tx_err), 32'd0);
        end
        bit_avail = 1'b0; bit_tick = 1'b0;
    endtask

    initial begin
        nRST = 1'b0; bit_tick = 1'b0; tx_start = 1'b0; bit_in = 1'b0;
        bit_avail = 1'b0; pkt_end = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_line", 32'({dp, dm}), 32'(J_L));
        check("rst_oe",   32'(oe),     32'd0);
        check("rst_busy", 32'(busy),   32'd0);
        check("rst_done", 32'(done),   32'd0);
        check("rst_err",  32'(tx_err), 32'd0);
        nRST = 1'b1;
        idle_cycles(3);

        // seven 0s then a 1, normal end
        pkt_q.delete();
        for (int i = 0; i < 7; i++) pkt_q.push_back(1'b0);
        pkt_q.push_back(1'b1);
        run_packet(1'b0, 1, 0, 1'b0);
        idle_cycles(2);

        // 0xFF: stuffed bit at the seventh bit time
        pkt_q.delete(); add_byte(8'hFF);
        run_packet(1'b0, 3, 0, 1'b0);
        idle_cycles(2);

        // 0x3F then 0x00
        pkt_q.delete(); add_byte(8'h3F); add_byte(8'h00);
        run_packet(1'b0, 2, 0, 1'b0);

        // exactly six trailing 1s at pkt_end
        pkt_q.delete(); pkt_q.push_back(1'b0);
        for (int i = 0; i < 6; i++) pkt_q.push_back(1'b1);
        run_packet(1'b0, 1, 0, 1'b0);

        // underrun straight after start and after some data
        pkt_q.delete();
        run_packet(1'b1, 2, 0, 1'b0);
        pkt_q.delete(); add_byte(8'hA5);
        run_packet(1'b1, 3, 0, 1'b0);
        idle_cycles(2);

        // reset mid-DATA: abort without EOP
        pkt_q.delete(); add_byte(8'h5A); add_byte(8'hFF);
        run_packet(1'b0, 2, 5, 1'b0);
        nRST = 1'b0;
        @(posedge clk); #1;
        nRST = 1'b1;
        check("midrst_line", 32'({dp, dm}), 32'(J_L));
        check("midrst_oe",   32'(oe),   32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        idle_cycles(12);

        // random packets with tx_start noise during the packet
        for (int p = 0; p < 24; p++) begin
            int unsigned len;
            bit          ur;
            pkt_q.delete();
            len = $urandom_range(0, 40);
            for (int i = 0; i < int'(len); i++) pkt_q.push_back($urandom_range(0, 3) != 0);
            ur = ($urandom_range(0, 3) == 0);
            run_packet(ur, $urandom_range(1, 4), 0, 1'b1);
            idle_cycles($urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
